rm_viol_collect_swlw: RTL
=========================

# rm_viol_collect_swlw

Downstream collector for the sw/lw runtime monitor. Consumes the four per-property LTL violation flags (ltl0..ltl3) produced by the swlw monitor top level, qualified by `run`. Latches sticky violation status, records the first violation (property id, symbol, run-cycle timestamp) and counts violations per property. Raises a level interrupt that software clears with an acknowledge handshake.

## Interface
- CNT_W, 8, width of each per-property saturating violation counter
- TS_W, 16, width of the run-cycle timestamp counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  monitor step strobe; flags and symbols are valid only when high
- symbols  in  8  symbol vector fed to the monitor in the same cycle
- ltl0c0swlw, ltl1c0swlw, ltl2c0swlw, ltl3c0swlw  in  1 each  property violation flags from the monitor
- ack  in  1  interrupt acknowledge, single-cycle pulse
- clr  in  1  synchronous full clear, single-cycle pulse
- irq  out  1  violation pending
- sticky  out  4  bit i set once property i has violated since the last ack/clr
- first_id  out  2  index of the first violating property
- first_symbol  out  8  `symbols` value at the first violation
- first_ts  out  TS_W  timestamp value at the first violation
- cnt_flat  out  4*CNT_W  per-property counters; property i at [i*CNT_W +: CNT_W]

## Operation
- Event cycle: `run`=1 and any flag=1. Flags are ignored when `run`=0.
- Timestamp counter `ts`: increments by 1 on every `run`=1 cycle and wraps modulo 2^TS_W. Cleared by reset/clr.
- FSM states:
  - IDLE: `irq`=0. On an event cycle, `sticky` |= flags. `first_id` takes the lowest set flag index, `first_symbol` takes `symbols`, and `first_ts` takes the current `ts` (pre-increment). Go to PEND.
  - PEND: `irq`=1. On an event cycle, `sticky` |= flags and the first_* registers hold.
  - PEND with `ack`=1: clear `sticky`, `first_id`, `first_symbol` and `first_ts` to 0, then go to IDLE. If the same cycle is also an event cycle, re-capture as IDLE would, with `sticky` = the new flags only, and stay in PEND.
  - `ack` in IDLE is ignored.
- Counters: on an event cycle, each counter whose flag is set increments by 1 and saturates at 2^CNT_W-1 (no wrap). `ack` does not clear the counters.
- `clr`:
  - Highest priority. Zeroes the counters, `ts`, `sticky` and all first_* registers, and forces IDLE.
  - An event in the same cycle is discarded; neither the counters nor `sticky` record it.
- Reset values: `irq`=0, `sticky`=0, `first_id`=0, `first_symbol`=0, `first_ts`=0, `cnt_flat`=0, FSM=IDLE, `ts`=0.
- All outputs are driven directly from registers.

## Timing
- Reset acts asynchronously on assertion. The block leaves reset at the first rising edge after deassertion.
- Latency: an event sampled at edge N is visible on `irq`, `sticky`, first_* and `cnt_flat` after edge N (same-cycle registered, latency 1).
- `ack` sampled at edge N drops `irq` after edge N, unless a re-capture occurs in the same cycle.
- Minimum IRQ low time after ack is 1 cycle only if no event occurs in that ack cycle.
- Back-to-back events every cycle are accepted; there is no backpressure to the monitor.

## Configuration
- RM_SWLW_VIOL_CNT_EN defined: the four saturating counters are built as described.
- Not defined: the counter registers are omitted and `cnt_flat` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset: hold `reset`=1 with flags toggling -> all outputs 0. Release it and drive `run`=1, ltl2=1, `symbols`=8'hA5 at `ts`=3 -> `irq`=1, `sticky`=4'b0100, `first_id`=2, `first_symbol`=8'hA5, `first_ts`=3.
- Priority and hold: event with ltl1 and ltl3 both set -> `first_id`=1. A later ltl0 event -> `sticky`=4'b1011, first_* unchanged.
- Run gating: ltl0=1 with `run`=0 for 10 cycles -> `irq`=0, counters 0, `ts` unchanged.
- Ack plus event: in PEND, `ack`=1 with ltl3 event and `symbols`=8'h3C -> `irq` stays 1, `sticky`=4'b1000, `first_id`=3, `first_symbol`=8'h3C. Ack alone next time -> `irq`=0, `sticky`=0.
- Saturation and clear: with CNT_W=8, 300 consecutive ltl0 events -> counter 0 = 255. Then `clr` with a simultaneous ltl0 event -> counter 0 = 0, `sticky`=0, `irq`=0, FSM IDLE. Without RM_SWLW_VIOL_CNT_EN -> `cnt_flat`=0 throughout.
- Timestamp wrap: with TS_W=4, 17 `run` cycles then an event -> `first_ts`=1.

Source files
------------

// File: rtl/rm_viol_collect_swlw.sv
// rm_viol_collect_swlw: violation collector for the sw/lw runtime monitor.
// Latches sticky per-property violation status and the first violation
// (property id, symbol, run-cycle timestamp). It raises a level interrupt
// that software clears with a single-cycle acknowledge.
// Optional feature macro: RM_SWLW_VIOL_CNT_EN builds the four saturating
// per-property violation counters; without it cnt_flat is tied to zero.
module rm_viol_collect_swlw #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [7:0]           symbols,
    input  logic                 ltl0c0swlw,
    input  logic                 ltl1c0swlw,
    input  logic                 ltl2c0swlw,
    input  logic                 ltl3c0swlw,
    input  logic                 ack,
    input  logic                 clr,
    output logic                 irq,
    output logic [3:0]           sticky,
    output logic [1:0]           first_id,
    output logic [7:0]           first_symbol,
    output logic [TS_W-1:0]      first_ts,
    output logic [4*CNT_W-1:0]   cnt_flat
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        sticky_q, sticky_d;
    logic [1:0]        firstId_q, firstId_d;
    logic [7:0]        firstSym_q, firstSym_d;
    logic [TS_W-1:0]   firstTs_q, firstTs_d;
    logic [TS_W-1:0]   ts_q, ts_d;

    logic [3:0]        flags;
    logic              eventHit;
    logic [1:0]        lowId;

    assign flags    = {ltl3c0swlw, ltl2c0swlw, ltl1c0swlw, ltl0c0swlw};
    assign eventHit = run & (|flags);

    // Lowest set flag index wins when several properties violate together
    always_comb begin
        lowId = 2'd0;
        if (flags[0])      lowId = 2'd0;
        else if (flags[1]) lowId = 2'd1;
        else if (flags[2]) lowId = 2'd2;
        else if (flags[3]) lowId = 2'd3;
    end

    // Next-state logic: clr dominates, ack in PEND wipes the capture, events capture or accumulate
    always_comb begin
        state_d    = state_q;
        sticky_d   = sticky_q;
        firstId_d  = firstId_q;
        firstSym_d = firstSym_q;
        firstTs_d  = firstTs_q;
        if (clr) begin
            state_d    = IDLE;
            sticky_d   = '0;
            firstId_d  = '0;
            firstSym_d = '0;
            firstTs_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eventHit) begin
                        sticky_d   = sticky_q | flags;
                        firstId_d  = lowId;
                        firstSym_d = symbols;
                        firstTs_d  = ts_q;
                        state_d    = PEND;
                    end
                end
                PEND: begin
                    if (ack) begin
                        sticky_d   = '0;
                        firstId_d  = '0;
                        firstSym_d = '0;
                        firstTs_d  = '0;
                        state_d    = IDLE;
                        if (eventHit) begin
                            sticky_d   = flags;
                            firstId_d  = lowId;
                            firstSym_d = symbols;
                            firstTs_d  = ts_q;
                            state_d    = PEND;
                        end
                    end else if (eventHit) begin
                        sticky_d = sticky_q | flags;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Run-cycle timestamp: counts every run strobe, wraps naturally
    always_comb begin
        ts_d = ts_q;
        if (clr)      ts_d = '0;
        else if (run) ts_d = ts_q + TS_W'(1);
    end

    // State, capture and timestamp registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sticky_q   <= '0;
            firstId_q  <= '0;
            firstSym_q <= '0;
            firstTs_q  <= '0;
            ts_q       <= '0;
        end else begin
            state_q    <= state_d;
            sticky_q   <= sticky_d;
            firstId_q  <= firstId_d;
            firstSym_q <= firstSym_d;
            firstTs_q  <= firstTs_d;
            ts_q       <= ts_d;
        end
    end

    assign irq          = (state_q == PEND);
    assign sticky       = sticky_q;
    assign first_id     = firstId_q;
    assign first_symbol = firstSym_q;
    assign first_ts     = firstTs_q;

`ifdef RM_SWLW_VIOL_CNT_EN
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per-property counters bump on events and stick at all-ones; clr discards the event
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            for (int i = 0; i < 4; i++) begin
                if (flags[i] && (cnt_q[i] != {CNT_W{1'b1}}))
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_flat = cnt_q;
`else
    assign cnt_flat = '0;
`endif

endmodule
